psa_accumulator: RTL

- Sequential consumer of packed nibble sums for the WISC ALU datapath.
- Accepts a stream of 16-bit operands, each holding four signed 4-bit lanes.
- Accumulates them into a 16-bit register using PADDSB semantics: per-lane signed saturating addition.
- Presents one result word with sticky per-lane saturation flags. Used for multi-operand PADDSB/RED-style reductions ahead of writeback.

---
 rtl/psa_accumulator.sv | 117 +++++++++++
 1 files changed

// File: rtl/psa_accumulator.sv
// rtl/psa_accumulator.sv - streaming per-lane signed saturating nibble accumulator
module psa_accumulator #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic [3:0]       sat_flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic [15:0]      acc;
    logic [3:0]       flags;
    logic [15:0]      sum_next;
    logic [3:0]       sat_next;
    logic             beat;

    // Returns {overflow, value} for a 4-bit signed saturating add.
    function automatic logic [4:0] sat4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] raw;
        raw = a + b;
        if (!a[3] && !b[3] && raw[3]) begin
            sat4 = {1'b1, 4'b0111};
        end else if (a[3] && b[3] && !raw[3]) begin
            sat4 = {1'b1, 4'b1000};
        end else begin
            sat4 = {1'b0, raw};
        end
    endfunction

    // Candidate next accumulator: four independent lanes, no carry between them.
    always_comb begin
        sum_next = '0;
        sat_next = '0;
        for (int i = 0; i < 4; i++) begin
            {sat_next[i], sum_next[4*i +: 4]} = sat4(acc[4*i +: 4], in_data[4*i +: 4]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && remaining == LEN_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign beat = in_valid && (state == ACCUM);

    // Accumulator, sticky flags and beat counter; cleared on reset and on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            flags     <= '0;
            remaining <= '0;
        end else if (state == IDLE && start) begin
            acc       <= '0;
            flags     <= '0;
            remaining <= len;
        end else if (beat) begin
            acc       <= sum_next;
            flags     <= flags | sat_next;
            remaining <= remaining - LEN_W'(1);
        end
    end

    assign result    = acc;
    assign sat_flags = flags;

endmodule
